// File: rtl/program_sequencer.sv
// Host-side program loader and run sequencer for the neural data path's code storage.
// Streams instruction words into code storage, then runs the program until halt, end, abort or timeout.
module program_sequencer #(
  parameter int unsigned MAX_LINES  = 256,
  parameter logic [3:0]  HALT_OP    = 4'hF,
  parameter int unsigned MAX_CYCLES = 65535,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             host_load_start,
  input  logic [11:0]      host_data,
  input  logic             host_valid,
  input  logic             host_last,
  output logic             host_ready,
  input  logic             host_run_start,
  input  logic             host_abort,
  output logic [11:0]      cs_write_data,
  output logic             cs_is_write,
  output logic [31:0]      cs_write_line,
  output logic             cs_active,
  output logic             cs_reset,
  input  logic [31:0]      code_index,
  input  logic [3:0]       parse_op,
  output logic             busy,
  output logic             done,
  output logic [31:0]      program_len,
  output logic [CNT_W-1:0] run_cycles,
  output logic [2:0]       status
);

  typedef enum logic [2:0] {StIdle, StClear, StLoad, StPcRst, StRun, StDone} state_e;

  localparam logic [31:0]      MaxLinesW = 32'(MAX_LINES);
  localparam logic [31:0]      LastLine  = 32'(MAX_LINES - 1);
  localparam logic [CNT_W-1:0] TimeoutAt = CNT_W'(MAX_CYCLES - 1);
  localparam bit               WdogEn    = (MAX_CYCLES != 0);

  state_e      state_q;
  logic [31:0] line_cnt_q;
  logic        accept;

  assign host_ready = (state_q == StLoad) && (line_cnt_q < MaxLinesW);
  assign busy       = (state_q != StIdle);
  assign accept     = host_valid && host_ready;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q       <= StIdle;
      line_cnt_q    <= '0;
      cs_write_data <= '0;
      cs_is_write   <= 1'b0;
      cs_write_line <= '0;
      cs_active     <= 1'b0;
      cs_reset      <= 1'b0;
      done          <= 1'b0;
      program_len   <= '0;
      run_cycles    <= '0;
      status        <= '0;
    end else begin
      // Pulse outputs default low; cs_reset is raised on entry to CLEAR/PCRST only.
      cs_is_write <= 1'b0;
      cs_reset    <= 1'b0;
      done        <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (host_load_start) begin
            state_q     <= StClear;
            cs_reset    <= 1'b1;
            line_cnt_q  <= '0;
            program_len <= '0;
            status      <= '0;
          end else if (host_run_start) begin
            if (program_len != 32'd0) begin
              state_q    <= StPcRst;
              cs_reset   <= 1'b1;
              run_cycles <= '0;
              status     <= '0;
            end else begin
              status <= 3'b001;
            end
          end
        end
        StClear: state_q <= StLoad;
        StLoad: begin
          if (host_abort) begin
            status[1]   <= 1'b1;
            program_len <= '0;
            state_q     <= StIdle;
          end else if (accept) begin
            cs_write_data <= host_data;
            cs_write_line <= line_cnt_q;
            cs_is_write   <= 1'b1;
            line_cnt_q    <= line_cnt_q + 32'd1;
            if (host_last) begin
              program_len <= line_cnt_q + 32'd1;
              state_q     <= StIdle;
            end else if (line_cnt_q == LastLine) begin
              // Storage full and the host still has not marked the last word.
              status[0]   <= 1'b1;
              program_len <= MaxLinesW;
              state_q     <= StIdle;
            end
          end
        end
        StPcRst: begin
          state_q   <= StRun;
          cs_active <= 1'b1;
        end
        StRun: begin
          if (run_cycles != '1) run_cycles <= run_cycles + 1'b1;
          if (host_abort) begin
            status[1] <= 1'b1;
            state_q   <= StDone;
            cs_active <= 1'b0;
            done      <= 1'b1;
          end else if ((parse_op == HALT_OP) || (code_index >= program_len)) begin
            state_q   <= StDone;
            cs_active <= 1'b0;
            done      <= 1'b1;
          end else if (WdogEn && (run_cycles == TimeoutAt)) begin
            status[2] <= 1'b1;
            state_q   <= StDone;
            cs_active <= 1'b0;
            done      <= 1'b1;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed self-checking bench for program_sequencer (MAX_LINES=4, MAX_CYCLES=10).
module tb_program_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        host_load_start = 1'b0;
  logic [11:0] host_data = '0;
  logic        host_valid = 1'b0;
  logic        host_last = 1'b0;
  logic        host_ready;
  logic        host_run_start = 1'b0;
  logic        host_abort = 1'b0;
  logic [11:0] cs_write_data;
  logic        cs_is_write;
  logic [31:0] cs_write_line;
  logic        cs_active;
  logic        cs_reset;
  logic [31:0] code_index = '0;
  logic [3:0]  parse_op = '0;
  logic        busy;
  logic        done;
  logic [31:0] program_len;
  logic [31:0] run_cycles;
  logic [2:0]  status;

  int n_checks = 0;
  int n_fail   = 0;
  bit excl_viol = 1'b0;

  program_sequencer #(
    .MAX_LINES (4),
    .HALT_OP   (4'hF),
    .MAX_CYCLES(10),
    .CNT_W     (32)
  ) dut (
    .clk_clk        (clk),
    .reset_reset_n  (rst_n),
    .host_load_start(host_load_start),
    .host_data      (host_data),
    .host_valid     (host_valid),
    .host_last      (host_last),
    .host_ready     (host_ready),
    .host_run_start (host_run_start),
    .host_abort     (host_abort),
    .cs_write_data  (cs_write_data),
    .cs_is_write    (cs_is_write),
    .cs_write_line  (cs_write_line),
    .cs_active      (cs_active),
    .cs_reset       (cs_reset),
    .code_index     (code_index),
    .parse_op       (parse_op),
    .busy           (busy),
    .done           (done),
    .program_len    (program_len),
    .run_cycles     (run_cycles),
    .status         (status)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cs_reset && cs_is_write) excl_viol = 1'b1;
    if (cs_active && (cs_reset || !busy)) excl_viol = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " ready"}, 32'(host_ready), 0);
    check({tag, " is_write"}, 32'(cs_is_write), 0);
    check({tag, " cs_reset"}, 32'(cs_reset), 0);
    check({tag, " cs_active"}, 32'(cs_active), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " program_len"}, program_len, 0);
    check({tag, " run_cycles"}, run_cycles, 0);
    check({tag, " status"}, 32'(status), 0);
  endtask

  // Starts a run and drives code_index = RUN cycle number (or 0 when hold_idx),
  // raising HALT_OP in cycle halt_at. Counts cycles with cs_active high.
  task automatic run_prog(input string tag, input int halt_at, input bit hold_idx,
                          output int act);
    bit got_done = 1'b0;
    host_run_start = 1'b1;
    step();
    host_run_start = 1'b0;
    check({tag, " pcrst cs_reset"}, 32'(cs_reset), 1);
    check({tag, " pcrst cs_active"}, 32'(cs_active), 0);
    step();
    act = 0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      code_index = hold_idx ? 32'd0 : 32'(c);
      parse_op   = (c == halt_at) ? 4'hF : 4'h0;
      if (cs_active) act++;
      step();
      if (done) got_done = 1'b1;
    end
    code_index = '0;
    parse_op   = '0;
    check({tag, " done seen"}, 32'(got_done), 1);
    check({tag, " cs_active after"}, 32'(cs_active), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout: got no finish, expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int act;

    // Reset state
    step(); step(); step();
    check_all_zero("reset");
    rst_n = 1'b1;
    step();

    // Load 0x101, 0x202, 0x303
    host_load_start = 1'b1;
    step();
    host_load_start = 1'b0;
    check("clear cs_reset", 32'(cs_reset), 1);
    check("clear busy", 32'(busy), 1);
    check("clear ready", 32'(host_ready), 0);
    step();
    check("load ready", 32'(host_ready), 1);
    check("load cs_reset", 32'(cs_reset), 0);
    host_valid = 1'b1;
    host_data  = 12'h101;
    check("w0 no early write", 32'(cs_is_write), 0);
    step();
    check("w0 is_write", 32'(cs_is_write), 1);
    check("w0 line", cs_write_line, 0);
    check("w0 data", 32'(cs_write_data), 32'h101);
    host_data = 12'h202;
    step();
    check("w1 is_write", 32'(cs_is_write), 1);
    check("w1 line", cs_write_line, 1);
    check("w1 data", 32'(cs_write_data), 32'h202);
    host_data = 12'h303;
    host_last = 1'b1;
    check("w2 ready", 32'(host_ready), 1);
    step();
    host_valid = 1'b0;
    host_last  = 1'b0;
    check("w2 is_write", 32'(cs_is_write), 1);
    check("w2 line", cs_write_line, 2);
    check("w2 data", 32'(cs_write_data), 32'h303);
    check("load program_len", program_len, 3);
    check("load busy fall", 32'(busy), 0);
    check("load status", 32'(status), 0);
    step();
    check("post-load is_write", 32'(cs_is_write), 0);

    // Normal run ending on code_index == program_len
    run_prog("run", -1, 1'b0, act);
    check("run active cycles", 32'(act), 4);
    check("run run_cycles", run_cycles, 4);
    check("run status", 32'(status), 0);
    step();
    check("run done once", 32'(done), 0);
    check("run idle", 32'(busy), 0);
    check("run len kept", program_len, 3);

    // Halt opcode in RUN cycle 2
    run_prog("halt", 2, 1'b0, act);
    check("halt active cycles", 32'(act), 3);
    check("halt run_cycles", run_cycles, 3);
    check("halt status", 32'(status), 0);
    step();
    check("halt done once", 32'(done), 0);

    // Watchdog with code_index stuck at 0
    run_prog("tmo", -1, 1'b1, act);
    check("tmo active cycles", 32'(act), 10);
    check("tmo run_cycles", run_cycles, 10);
    check("tmo status", 32'(status), 32'b100);
    step();
    check("tmo done once", 32'(done), 0);

    // Abort mid-run
    host_run_start = 1'b1;
    step();
    host_run_start = 1'b0;
    step();
    step();
    check("abrun active", 32'(cs_active), 1);
    host_abort = 1'b1;
    step();
    host_abort = 1'b0;
    check("abrun cs_active", 32'(cs_active), 0);
    check("abrun done", 32'(done), 1);
    check("abrun status", 32'(status), 32'b010);
    check("abrun run_cycles", run_cycles, 2);
    step();

    // Abort mid-load drops the word offered with the abort
    host_load_start = 1'b1;
    step();
    host_load_start = 1'b0;
    step();
    host_valid = 1'b1;
    host_data  = 12'h0AA;
    step();
    check("abld w0 is_write", 32'(cs_is_write), 1);
    host_data  = 12'h0BB;
    host_abort = 1'b1;
    step();
    host_abort = 1'b0;
    host_valid = 1'b0;
    check("abld dropped", 32'(cs_is_write), 0);
    check("abld status", 32'(status), 32'b010);
    check("abld program_len", program_len, 0);
    check("abld busy", 32'(busy), 0);

    // Run with nothing loaded
    host_run_start = 1'b1;
    step();
    host_run_start = 1'b0;
    check("empty run status", 32'(status), 32'b001);
    check("empty run busy", 32'(busy), 0);
    check("empty run cs_reset", 32'(cs_reset), 0);

    // Overflow: four words without last
    host_load_start = 1'b1;
    step();
    host_load_start = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      host_valid = 1'b1;
      host_data  = 12'(16 + i);
      check("ovf ready", 32'(host_ready), 1);
      step();
      check("ovf is_write", 32'(cs_is_write), 1);
      check("ovf line", cs_write_line, 32'(i));
    end
    host_data = 12'h055;
    check("ovf 5th ready", 32'(host_ready), 0);
    check("ovf status", 32'(status), 32'b001);
    check("ovf program_len", program_len, 4);
    step();
    host_valid = 1'b0;
    check("ovf 5th dropped", 32'(cs_is_write), 0);

    // Reset during RUN
    host_run_start = 1'b1;
    step();
    host_run_start = 1'b0;
    step();
    check("rstrun active", 32'(cs_active), 1);
    rst_n = 1'b0;
    step();
    check_all_zero("rstrun");
    rst_n = 1'b1;
    step();
    check("rstrun idle", 32'(busy), 0);

    check("reset/write overlap", 32'(excl_viol), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
